packet_output_arbiter: RTL and testbench
========================================

# packet_output_arbiter

Per-output-port arbiter of the AXI-Stream router: it sits directly downstream of the routing-algorithm stages. Each of the `CHANNEL_NUMBER` input-port routing stages drives one request into each output port's arbiter. The arbiter grants one input at a time in round-robin order, locks that grant for a whole packet (routing header through the TLAST beat) and forwards the winner's beats to the output link. Optionally it registers the output through a skid buffer.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, default 32: TDATA width; sizes `axis_mosi_t`.
- `ID_WIDTH` / `DEST_WIDTH` / `USER_WIDTH`, default 4 each: present only under `TID_PRESENT` / `TDEST_PRESENT` / `TUSER_PRESENT`.
- `CHANNEL_NUMBER`, default 5: number of requesting input ports.
- `CHANNEL_NUMBER_WIDTH`, default `$clog2(CHANNEL_NUMBER)`: width of grant index and pointer.

Ports:
- `clk_i`, input, 1: clock.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `in_mosi_i`, input, `axis_mosi_t [CHANNEL_NUMBER]`: beat from each input port's routing stage.
- `in_miso_o`, output, `axis_miso_t [CHANNEL_NUMBER]`: TREADY back to each input.
- `out_mosi_o`, output, `axis_mosi_t`: beat to the output link.
- `out_miso_i`, input, `axis_miso_t`: TREADY from the output link.

## Operation
- Packet framing:
  - A packet starts with a beat whose `TID == ROUTING_HEADER`.
  - It ends with the first following beat that has `TLAST=1` and `TID != ROUTING_HEADER`.
  - A header beat never ends a packet, even if its TLAST is 1.
- Request: input i requests when `in_mosi_i[i].TVALID && in_mosi_i[i].data.TID == ROUTING_HEADER`.
- FSM states:
  - IDLE:
    - The winner is the first requesting index at or after `rr_ptr`, searching upward with wrap from `CHANNEL_NUMBER-1` to 0.
    - The winner's header is forwarded combinationally in the same cycle.
    - On handshake (`TVALID && TREADY` at the output), latch `grant=winner`, set `rr_ptr = (winner+1) mod CHANNEL_NUMBER` and go to LOCKED.
    - With no handshake, stay in IDLE. `rr_ptr` does not move, so the winner can change next cycle.
  - LOCKED:
    - `out_mosi_o = in_mosi_i[grant]`.
    - `in_miso_o[grant].TREADY = out_miso_i.TREADY`.
    - A handshake on a terminating beat returns the FSM to IDLE.
- Non-granted inputs always see `TREADY=0`. This includes non-header beats arriving on a non-granted input while in IDLE (protocol violation): they are stalled and never forwarded.
- With no requests in IDLE, `out_mosi_o = '0`.
- Simultaneous events:
  - A packet that ends in cycle N re-arbitrates in cycle N+1. The just-served input has the lowest priority.
  - A new header on the same input in cycle N+1 is legal and competes normally.
- Reset:
  - `state=IDLE`, `rr_ptr=0`, `grant=0`.
  - `out_mosi_o='0`; all `in_miso_o='0`.
  - Reset mid-packet discards the lock immediately. No beat is forwarded during reset.

## Timing
- Without skid:
  - Zero-cycle latency: input to output is purely combinational through a mux on `grant` (or on `winner` in IDLE).
  - Full throughput: one beat per cycle.
  - The TREADY path from output to inputs is combinational.
- With skid:
  - One-cycle latency.
  - One beat per cycle sustained.
  - `in_miso_o` is driven from the buffer's not-full state only, with no combinational path from `out_miso_i`.
- `rr_ptr` and `state` update only on an output-side handshake. In skid mode, that means the handshake into the skid buffer.

## Configuration
- Macro `PACKET_ARBITER_SKID_EN`.
- When defined:
  - A 2-entry skid buffer registers the forwarded stream.
  - `out_mosi_o` comes from a flop and is `'0` at reset.
  - The upstream-facing TREADY = buffer has at least one free entry.
  - Buffer full with output stalled: TREADY=0, contents held.
  - Simultaneous push and pop on a full buffer: the pop frees one entry, and TREADY is reasserted the next cycle.
- When undefined: the combinational path described above, with no storage.

## Structure
- `ROUTING_HEADER` belongs in the shared router package.
- The `axis_mosi_t` / `axis_miso_t` typedefs come from the shared router package.
- Sub-module `rr_arbiter`: combinational. Takes the request vector and `rr_ptr` and returns `winner` (index) and `any_req`.
- The FSM, pointer and skid buffer live in `packet_output_arbiter`.

## Test plan
- Single input 2 requests a 4-beat packet (header, 2 body, TLAST body) with output always ready:
  - Without skid: all 4 beats appear in the same cycles.
  - `rr_ptr` = 3 after the packet.
  - Returns to IDLE after beat 4.
- Inputs 0, 1 and 3 request simultaneously with `rr_ptr=0`:
  - Packets are served in order 0, 1, 3 with no interleaving.
  - `rr_ptr` goes 1 → 2 → 4.
- Input 1 is locked and input 0 presents a header mid-packet:
  - `in_miso_o[0].TREADY` stays 0 until input 1's TLAST handshake.
  - Input 0 is granted the next cycle.
- Output TREADY toggles 1,0,0,1 during a packet: no beat is lost or duplicated, and the held beat stays stable.
- Reset is asserted after the header of a 3-beat packet:
  - Outputs go to `'0`, state IDLE, `rr_ptr=0`.
  - After release, the next header is arbitrated fresh.
- With `PACKET_ARBITER_SKID_EN` and output stalled for 3 cycles:
  - The buffer fills 2 entries, then upstream TREADY=0.
  - On release, beats drain in order with one-cycle latency.

Source files
------------

// File: rtl/packet_output_arbiter_pkg.sv
// packet_output_arbiter_pkg: shared router AXI-Stream types, routing-header TID and arbiter FSM states.
// TDEST/TUSER fields appear only under TDEST_PRESENT / TUSER_PRESENT; TID is always carried for framing.
package packet_output_arbiter_pkg;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_ID_W = 4;
  localparam int PKG_DEST_W = 4;
  localparam int PKG_USER_W = 4;
  localparam logic [PKG_ID_W-1:0] ROUTING_HEADER = 4'hF;
  typedef struct packed {
`ifdef TUSER_PRESENT
    logic [PKG_USER_W-1:0] TUSER;
`endif
`ifdef TDEST_PRESENT
    logic [PKG_DEST_W-1:0] TDEST;
`endif
    logic [PKG_ID_W-1:0] TID;
    logic TLAST;
    logic [PKG_DATA_W-1:0] TDATA;
  } axis_data_t;
  typedef struct packed {
    logic TVALID;
    axis_data_t data;
  } axis_mosi_t;
  typedef struct packed {
    logic TREADY;
  } axis_miso_t;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  // A header beat never closes a packet, even with TLAST set.
  function automatic logic is_terminator(input axis_data_t d);
    return d.TLAST && d.TID != ROUTING_HEADER;
  endfunction
endpackage

// File: rtl/packet_output_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr_i, with wrap.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic [W-1:0] winner_o,
  output logic         any_req_o
);
  int idx;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner_o = '0;
    any_req_o = 1'b0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        winner_o = W'(idx);
        any_req_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/packet_output_arbiter.sv
// packet_output_arbiter: per-output round-robin packet arbiter, grant locked from routing header to TLAST.
// Define PACKET_ARBITER_SKID_EN to register the output through a 2-entry skid buffer.
module packet_output_arbiter
  import packet_output_arbiter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = PKG_DATA_W,
  parameter int ID_WIDTH = PKG_ID_W,
  parameter int DEST_WIDTH = PKG_DEST_W,
  parameter int USER_WIDTH = PKG_USER_W,
  parameter int CHANNEL_NUMBER = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  axis_mosi_t [CHANNEL_NUMBER-1:0]     in_mosi_i,
  output axis_miso_t [CHANNEL_NUMBER-1:0]     in_miso_o,
  output axis_mosi_t                          out_mosi_o,
  input  axis_miso_t                          out_miso_i
);
  localparam int N = CHANNEL_NUMBER;
  localparam int W = CHANNEL_NUMBER_WIDTH;

  // The stream types live in the shared package, so the widths must agree with it.
  if (AXIS_DATA_WIDTH != PKG_DATA_W || ID_WIDTH != PKG_ID_W || DEST_WIDTH != PKG_DEST_W ||
      USER_WIDTH != PKG_USER_W) begin : g_cfg_check
    $error("packet_output_arbiter: widths must match packet_output_arbiter_pkg");
  end

  arb_state_e state_q, state_d;
  logic [W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner, sel;
  logic [N-1:0] req;
  logic any_req, live, ds_ready, hs;
  axis_mosi_t fwd;

  always_comb
    for (int i = 0; i < N; i++) req[i] = in_mosi_i[i].TVALID && in_mosi_i[i].data.TID == ROUTING_HEADER;

  rr_arbiter #(.N(N), .W(W)) u_rr (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .any_req_o(any_req)
  );

  always_comb begin
    sel = state_q == LOCKED ? grant_q : winner;
    live = rst_n_i && (state_q == LOCKED || any_req);
    fwd = live ? in_mosi_i[sel] : '0;
    hs = fwd.TVALID && ds_ready;
    for (int i = 0; i < N; i++) in_miso_o[i].TREADY = live && ds_ready && sel == W'(i);
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && hs) begin
      state_d = LOCKED;
      grant_d = winner;
      rr_ptr_d = winner == W'(N - 1) ? '0 : winner + 1'b1;
    end else if (state_q == LOCKED && hs && is_terminator(fwd.data)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end

`ifdef PACKET_ARBITER_SKID_EN
  axis_mosi_t [1:0] skid_q;
  logic [1:0] cnt_q;
  logic pop;
  // Upstream readiness comes only from occupancy, never from out_miso_i.
  assign ds_ready = cnt_q != 2'd2;
  assign pop = cnt_q != 2'd0 && out_miso_i.TREADY;
  assign out_mosi_o = cnt_q != 2'd0 ? skid_q[0] : '0;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      skid_q <= '0;
      cnt_q <= '0;
    end else begin
      if (pop) skid_q[0] <= skid_q[1];
      if (hs) skid_q[1'(cnt_q - 2'(pop))] <= fwd;
      cnt_q <= cnt_q + 2'(hs) - 2'(pop);
    end
`else
  assign ds_ready = out_miso_i.TREADY;
  assign out_mosi_o = fwd;
`endif
endmodule

// File: tb/tb_packet_output_arbiter.sv
// tb_packet_output_arbiter: directed self-checking bench for packet_output_arbiter (both build variants).
module tb_packet_output_arbiter;
  import packet_output_arbiter_pkg::*;
  localparam int N = 5;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  axis_mosi_t [N-1:0] in_mosi;
  axis_miso_t [N-1:0] in_miso;
  axis_mosi_t out_mosi;
  axis_miso_t out_miso;
  logic [N-1:0] rdy;
  int checks = 0;
  int errors = 0;

  packet_output_arbiter dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_mosi_i (in_mosi),
    .in_miso_o (in_miso),
    .out_mosi_o(out_mosi),
    .out_miso_i(out_miso)
  );

  always #5 clk_i = ~clk_i;

  always_comb for (int i = 0; i < N; i++) rdy[i] = in_miso[i].TREADY;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input int ch, input logic v, input logic hdr, input logic [31:0] d, input logic last);
    in_mosi[ch] = '0;
    in_mosi[ch].TVALID = v;
    in_mosi[ch].data.TID = hdr ? ROUTING_HEADER : '0;
    in_mosi[ch].data.TDATA = d;
    in_mosi[ch].data.TLAST = last;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d, input logic [N-1:0] r);
    #1;
    chk({tag, ".valid"}, out_mosi.TVALID, v);
    chk({tag, ".data"}, out_mosi.data.TDATA, d);
    chk({tag, ".ready"}, rdy, r);
  endtask

  task automatic expect_fsm(input string tag, input arb_state_e st, input logic [2:0] g, input logic [2:0] p);
    chk({tag, ".state"}, dut.state_q, st);
    chk({tag, ".grant"}, dut.grant_q, g);
    chk({tag, ".rr_ptr"}, dut.rr_ptr_q, p);
  endtask

  initial begin
    in_mosi = '0;
    out_miso.TREADY = 1'b1;
    beat(0, 1, 1, 32'hDEAD, 0);
    #12;
    expect_out("rst", 0, 0, 5'b00000);
    expect_fsm("rst", IDLE, 0, 0);
    chk("rst.word", out_mosi, '0);
    beat(0, 0, 0, 0, 0);
    tick();
    rst_n_i = 1'b1;
    tick();
`ifndef PACKET_ARBITER_SKID_EN
    beat(2, 1, 1, 32'hA0, 0);
    expect_out("p2.hdr", 1, 32'hA0, 5'b00100);
    tick();
    expect_fsm("p2.lock", LOCKED, 2, 3);
    beat(2, 1, 0, 32'hA1, 0);
    expect_out("p2.b1", 1, 32'hA1, 5'b00100);
    tick();
    beat(2, 1, 0, 32'hA2, 0);
    expect_out("p2.b2", 1, 32'hA2, 5'b00100);
    tick();
    beat(2, 1, 0, 32'hA3, 1);
    expect_out("p2.b3", 1, 32'hA3, 5'b00100);
    chk("p2.tlast", out_mosi.data.TLAST, 1'b1);
    tick();
    beat(2, 0, 0, 0, 0);
    expect_out("p2.idle", 0, 0, 5'b00000);
    chk("p2.zero", out_mosi, '0);
    expect_fsm("p2.end", IDLE, 2, 3);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    beat(0, 1, 1, 32'h100, 0);
    beat(1, 1, 1, 32'h110, 0);
    beat(3, 1, 1, 32'h130, 0);
    expect_out("rr.h0", 1, 32'h100, 5'b00001);
    tick();
    expect_fsm("rr.l0", LOCKED, 0, 1);
    beat(0, 1, 0, 32'h101, 1);
    expect_out("rr.b0", 1, 32'h101, 5'b00001);
    tick();
    beat(0, 0, 0, 0, 0);
    expect_out("rr.h1", 1, 32'h110, 5'b00010);
    tick();
    expect_fsm("rr.l1", LOCKED, 1, 2);
    beat(1, 1, 0, 32'h111, 1);
    expect_out("rr.b1", 1, 32'h111, 5'b00010);
    tick();
    beat(1, 0, 0, 0, 0);
    expect_out("rr.h3", 1, 32'h130, 5'b01000);
    tick();
    expect_fsm("rr.l3", LOCKED, 3, 4);
    beat(3, 1, 0, 32'h131, 1);
    expect_out("rr.b3", 1, 32'h131, 5'b01000);
    tick();
    beat(3, 0, 0, 0, 0);
    #1;
    expect_fsm("rr.end", IDLE, 3, 4);
    beat(1, 1, 1, 32'h210, 0);
    expect_out("lk.h1", 1, 32'h210, 5'b00010);
    tick();
    beat(0, 1, 1, 32'h200, 0);
    beat(1, 1, 0, 32'h211, 0);
    expect_out("lk.b1", 1, 32'h211, 5'b00010);
    tick();
    beat(1, 1, 0, 32'h212, 1);
    expect_out("lk.b2", 1, 32'h212, 5'b00010);
    tick();
    beat(1, 0, 0, 0, 0);
    expect_out("lk.h0", 1, 32'h200, 5'b00001);
    tick();
    expect_fsm("lk.l0", LOCKED, 0, 1);
    beat(0, 1, 0, 32'h201, 0);
    out_miso.TREADY = 1'b0;
    expect_out("bp.s1", 1, 32'h201, 5'b00000);
    tick();
    expect_out("bp.s2", 1, 32'h201, 5'b00000);
    tick();
    out_miso.TREADY = 1'b1;
    expect_out("bp.go", 1, 32'h201, 5'b00001);
    tick();
    beat(0, 1, 0, 32'h202, 1);
    expect_out("bp.b2", 1, 32'h202, 5'b00001);
    tick();
    beat(0, 0, 0, 0, 0);
    #1;
    expect_fsm("bp.end", IDLE, 0, 1);
    beat(3, 1, 1, 32'h330, 0);
    expect_out("mr.h3", 1, 32'h330, 5'b01000);
    tick();
    expect_fsm("mr.l3", LOCKED, 3, 4);
    beat(3, 1, 0, 32'h331, 0);
    rst_n_i = 1'b0;
    expect_out("mr.rst", 0, 0, 5'b00000);
    chk("mr.zero", out_mosi, '0);
    expect_fsm("mr.rst", IDLE, 0, 0);
    tick();
    rst_n_i = 1'b1;
    beat(2, 1, 1, 32'h320, 0);
    beat(3, 1, 1, 32'h3F0, 0);
    expect_out("mr.fresh", 1, 32'h320, 5'b00100);
    tick();
    expect_fsm("mr.l2", LOCKED, 2, 3);
`else
    out_miso.TREADY = 1'b0;
    beat(0, 1, 1, 32'h500, 0);
    expect_out("sk.s0", 0, 0, 5'b00001);
    tick();
    expect_fsm("sk.l0", LOCKED, 0, 1);
    beat(0, 1, 0, 32'h501, 0);
    expect_out("sk.s1", 1, 32'h500, 5'b00001);
    tick();
    beat(0, 1, 0, 32'h502, 0);
    expect_out("sk.full", 1, 32'h500, 5'b00000);
    tick();
    expect_out("sk.hold", 1, 32'h500, 5'b00000);
    tick();
    out_miso.TREADY = 1'b1;
    expect_out("sk.rel", 1, 32'h500, 5'b00000);
    tick();
    expect_out("sk.d1", 1, 32'h501, 5'b00001);
    tick();
    beat(0, 1, 0, 32'h503, 1);
    expect_out("sk.d2", 1, 32'h502, 5'b00001);
    tick();
    beat(0, 0, 0, 0, 0);
    expect_out("sk.d3", 1, 32'h503, 5'b00000);
    chk("sk.tlast", out_mosi.data.TLAST, 1'b1);
    expect_fsm("sk.end", IDLE, 0, 1);
    tick();
    expect_out("sk.empty", 0, 0, 5'b00000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
